// File: rtl/ghost_mode_scheduler_if.sv
// Signal bundle between the game controller / monster logic and ghost_mode_scheduler.
// master = controller side (drives events), slave = scheduler side (drives mode outputs).
interface ghost_mode_scheduler_if;
    logic       playGame;
    logic       frameTick;
    logic       levelRestart;
    logic       powerPellet;
    logic       ghostEaten;
    logic [1:0] mode;
    logic       reverseDir;
    logic       frightFlash;
    logic [1:0] eatStreak;

    modport master (
        output playGame, frameTick, levelRestart, powerPellet, ghostEaten,
        input  mode, reverseDir, frightFlash, eatStreak
    );

    modport slave (
        input  playGame, frameTick, levelRestart, powerPellet, ghostEaten,
        output mode, reverseDir, frightFlash, eatStreak
    );
endinterface

// File: rtl/ghost_mode_scheduler.sv
// Ghost behaviour-mode sequencer: scatter/chase timetable, frightened episodes, eat streak.
// Optional end-of-fright flashing is built only when FRIGHT_FLASH_EN is defined.
module ghost_mode_scheduler #(
    parameter int unsigned SEC_TICKS    = 60,
    parameter int unsigned FRIGHT_SEC   = 6,
    parameter int unsigned FLASH_SEC    = 2,
    parameter int unsigned FLASH_FRAMES = 10
) (
    input  logic                   clk,
    input  logic                   resetN,
    ghost_mode_scheduler_if.slave  sched_if
);
    localparam int unsigned FW = (SEC_TICKS  > 1) ? $clog2(SEC_TICKS)  : 1;
    localparam int unsigned SW = 5;
    localparam int unsigned QW = (FRIGHT_SEC > 1) ? $clog2(FRIGHT_SEC) : 1;

    localparam logic [FW-1:0] FR_LAST = FW'(SEC_TICKS - 1);
    localparam logic [QW-1:0] FS_LAST = QW'(FRIGHT_SEC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SCATTER = 2'b01,
        CHASE   = 2'b10,
        FRIGHT  = 2'b11
    } state_t;

    state_t        st_q, st_d;
    logic [2:0]    phase_q, phase_d;
    logic [FW-1:0] sfr_q, sfr_d;
    logic [SW-1:0] ssec_q, ssec_d;
    logic [FW-1:0] ffr_q, ffr_d;
    logic [QW-1:0] fsec_q, fsec_d;
    logic [1:0]    streak_q, streak_d;
    logic          rev_q, rev_d;
    logic          rev_req;
    logic          fr_tick;
    logic          fr_clear;

    function automatic logic [SW-1:0] phase_last_sec(input logic [2:0] p);
        case (p)
            3'd0, 3'd2:       phase_last_sec = 5'd6;
            3'd1, 3'd3, 3'd5: phase_last_sec = 5'd19;
            3'd4, 3'd6:       phase_last_sec = 5'd4;
            default:          phase_last_sec = 5'd0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            st_q     <= IDLE;
            phase_q  <= '0;
            sfr_q    <= '0;
            ssec_q   <= '0;
            ffr_q    <= '0;
            fsec_q   <= '0;
            streak_q <= '0;
            rev_q    <= 1'b0;
        end else begin
            st_q     <= st_d;
            phase_q  <= phase_d;
            sfr_q    <= sfr_d;
            ssec_q   <= ssec_d;
            ffr_q    <= ffr_d;
            fsec_q   <= fsec_d;
            streak_q <= streak_d;
            rev_q    <= rev_d;
        end
    end

    always_comb begin
        st_d     = st_q;
        phase_d  = phase_q;
        sfr_d    = sfr_q;
        ssec_d   = ssec_q;
        ffr_d    = ffr_q;
        fsec_d   = fsec_q;
        streak_d = streak_q;
        rev_req  = 1'b0;
        fr_tick  = 1'b0;
        fr_clear = 1'b0;

        if (!sched_if.playGame) begin
            st_d     = IDLE;
            phase_d  = '0;
            sfr_d    = '0;
            ssec_d   = '0;
            ffr_d    = '0;
            fsec_d   = '0;
            streak_d = '0;
            fr_clear = 1'b1;
        end else begin
            case (st_q)
                IDLE: begin
                    st_d    = SCATTER;
                    phase_d = '0;
                    sfr_d   = '0;
                    ssec_d  = '0;
                end
                default: begin
                    if (sched_if.levelRestart) begin
                        st_d     = SCATTER;
                        phase_d  = '0;
                        sfr_d    = '0;
                        ssec_d   = '0;
                        ffr_d    = '0;
                        fsec_d   = '0;
                        streak_d = '0;
                        fr_clear = 1'b1;
                    end else if (sched_if.powerPellet) begin
                        // The coincident frameTick is dropped so the schedule stays frozen exactly here.
                        st_d     = FRIGHT;
                        ffr_d    = '0;
                        fsec_d   = '0;
                        streak_d = '0;
                        fr_clear = 1'b1;
                        rev_req  = (st_q != FRIGHT);
                    end else if (st_q == FRIGHT) begin
                        if (sched_if.ghostEaten && streak_q != 2'd3)
                            streak_d = streak_q + 2'd1;
                        if (sched_if.frameTick) begin
                            if (ffr_q == FR_LAST) begin
                                ffr_d = '0;
                                if (fsec_q == FS_LAST) begin
                                    fsec_d   = '0;
                                    st_d     = phase_q[0] ? CHASE : SCATTER;
                                    fr_clear = 1'b1;
                                end else begin
                                    fsec_d  = fsec_q + 1'b1;
                                    fr_tick = 1'b1;
                                end
                            end else begin
                                ffr_d   = ffr_q + 1'b1;
                                fr_tick = 1'b1;
                            end
                        end
                    end else if (sched_if.frameTick && phase_q != 3'd7) begin
                        if (sfr_q == FR_LAST) begin
                            sfr_d = '0;
                            if (ssec_q == phase_last_sec(phase_q)) begin
                                ssec_d  = '0;
                                phase_d = phase_q + 3'd1;
                                st_d    = (st_q == SCATTER) ? CHASE : SCATTER;
                                rev_req = 1'b1;
                            end else begin
                                ssec_d = ssec_q + 1'b1;
                            end
                        end else begin
                            sfr_d = sfr_q + 1'b1;
                        end
                    end
                end
            endcase
        end

        // Back-to-back requests (expiry then pellet) collapse to a single pulse.
        rev_d = rev_req & ~rev_q;
    end

`ifdef FRIGHT_FLASH_EN
    localparam int unsigned   LW       = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam logic [LW-1:0] FL_LAST  = LW'(FLASH_FRAMES - 1);
    localparam logic [QW-1:0] FS_FLASH = QW'(FRIGHT_SEC - FLASH_SEC);

    logic          flash_q, flash_d;
    logic [LW-1:0] flfr_q, flfr_d;

    always_comb begin
        flash_d = flash_q;
        flfr_d  = flfr_q;
        if (st_d != FRIGHT || fr_clear) begin
            flash_d = 1'b0;
            flfr_d  = '0;
        end else if (fr_tick) begin
            if (fsec_q >= FS_FLASH) begin
                if (flfr_q == FL_LAST) begin
                    flfr_d  = '0;
                    flash_d = ~flash_q;
                end else begin
                    flfr_d = flfr_q + 1'b1;
                end
            end else if (fsec_d == FS_FLASH) begin
                flash_d = 1'b1;
                flfr_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            flash_q <= 1'b0;
            flfr_q  <= '0;
        end else begin
            flash_q <= flash_d;
            flfr_q  <= flfr_d;
        end
    end

    assign sched_if.frightFlash = flash_q;
`else
    localparam int unsigned FLASH_CFG_UNUSED = FLASH_SEC + FLASH_FRAMES;
    logic flash_unused;
    assign flash_unused         = fr_tick | fr_clear;
    assign sched_if.frightFlash = 1'b0;
`endif

    assign sched_if.mode       = st_q;
    assign sched_if.reverseDir = rev_q;
    assign sched_if.eatStreak  = streak_q;
endmodule

// File: tb/tb_ghost_mode_scheduler.sv
// Bench for ghost_mode_scheduler: directed steps plus random events, checked against a
// tick-count reference model of the mode timetable.
module tb_ghost_mode_scheduler;
    localparam int SEC  = 4;
    localparam int FSEC = 6;
    localparam int FLS  = 2;
    localparam int FLF  = 2;

    logic clk    = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    ghost_mode_scheduler_if bus ();

    ghost_mode_scheduler #(
        .SEC_TICKS   (SEC),
        .FRIGHT_SEC  (FSEC),
        .FLASH_SEC   (FLS),
        .FLASH_FRAMES(FLF)
    ) dut (
        .clk     (clk),
        .resetN  (resetN),
        .sched_if(bus)
    );

    int total    = 0;
    int bad      = 0;
    int revCount = 0;

    // Reference state: mode, phase, ticks used in phase, ticks elapsed in fright.
    int m_mode   = 0;
    int m_phase  = 0;
    int m_used   = 0;
    int m_fel    = 0;
    int m_streak = 0;
    bit m_rev    = 1'b0;
    int dur[8]   = '{7, 20, 7, 20, 5, 20, 5, 0};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_flash();
`ifdef FRIGHT_FLASH_EN
        int start = (FSEC - FLS) * SEC;
        if (m_mode == 3 && m_fel >= start)
            return (((m_fel - start) / FLF) % 2 == 0) ? 1 : 0;
`endif
        return 0;
    endfunction

    task automatic model_step(input bit pg, input bit tk, input bit lr, input bit pp, input bit ge);
        bit want = 1'b0;
        if (!pg) begin
            m_mode = 0; m_phase = 0; m_used = 0; m_fel = 0; m_streak = 0;
        end else if (m_mode == 0) begin
            m_mode = 1; m_phase = 0; m_used = 0; m_fel = 0;
        end else if (lr) begin
            m_mode = 1; m_phase = 0; m_used = 0; m_fel = 0; m_streak = 0;
        end else if (pp) begin
            want = (m_mode != 3);
            m_mode = 3; m_fel = 0; m_streak = 0;
        end else if (m_mode == 3) begin
            if (ge && m_streak < 3) m_streak++;
            if (tk) begin
                m_fel++;
                if (m_fel == FSEC * SEC) begin
                    m_fel  = 0;
                    m_mode = (m_phase % 2 == 1) ? 2 : 1;
                end
            end
        end else if (tk && m_phase < 7) begin
            m_used++;
            if (m_used == dur[m_phase] * SEC) begin
                m_used = 0;
                m_phase++;
                m_mode = (m_phase % 2 == 1) ? 2 : 1;
                want = 1'b1;
            end
        end
        m_rev = want && !m_rev;
    endtask

    task automatic step(input bit pg, input bit tk, input bit lr, input bit pp, input bit ge);
        bus.playGame     = pg;
        bus.frameTick    = tk;
        bus.levelRestart = lr;
        bus.powerPellet  = pp;
        bus.ghostEaten   = ge;
        @(posedge clk);
        model_step(pg, tk, lr, pp, ge);
        #1;
        check("mode",        8'(bus.mode),        8'(m_mode));
        check("reverseDir",  8'(bus.reverseDir),  8'(m_rev));
        check("frightFlash", 8'(bus.frightFlash), 8'(exp_flash()));
        check("eatStreak",   8'(bus.eatStreak),   8'(m_streak));
        if (bus.reverseDir === 1'b1) revCount++;
    endtask

    initial begin
        bus.playGame     = 1'b0;
        bus.frameTick    = 1'b0;
        bus.levelRestart = 1'b0;
        bus.powerPellet  = 1'b0;
        bus.ghostEaten   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_mode",   8'(bus.mode),        8'd0);
        check("reset_rev",    8'(bus.reverseDir),  8'd0);
        check("reset_flash",  8'(bus.frightFlash), 8'd0);
        check("reset_streak", 8'(bus.eatStreak),   8'd0);
        resetN = 1'b1;

        step(0, 1, 0, 0, 0);
        check("idle_mode", 8'(bus.mode), 8'd0);

        // Full timetable: 336 ticks, then chase forever.
        revCount = 0;
        step(1, 1, 0, 0, 0);
        repeat (336 + 40) step(1, 1, 0, 0, 0);
        check("rev_total", 8'(revCount), 8'd7);
        check("final_chase", 8'(bus.mode), 8'd2);

        // Pellet at scatter tick 10, five ghosts, a second pellet, run to exit and resume.
        step(1, 1, 1, 0, 0);
        repeat (10) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        check("fright_enter_rev", 8'(bus.reverseDir), 8'd1);
        repeat (5) step(1, 1, 0, 0, 1);
        check("streak_sat", 8'(bus.eatStreak), 8'd3);
        repeat (8) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        check("repellet_rev", 8'(bus.reverseDir), 8'd0);
        check("repellet_streak", 8'(bus.eatStreak), 8'd0);
        repeat (50) step(1, 1, 0, 0, 0);

        // Pellet on the very tick the scatter phase would expire.
        step(1, 1, 1, 0, 0);
        repeat (27) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0);
        repeat (24) step(1, 1, 0, 0, 0);
        check("resume_scatter", 8'(bus.mode), 8'd1);
        step(1, 1, 0, 0, 0);
        check("deferred_expiry", 8'(bus.mode), 8'd2);
        repeat (3) step(1, 1, 0, 0, 0);

        // Pellet together with levelRestart, then playGame dropping mid-fright.
        step(1, 1, 1, 1, 0);
        check("restart_wins", 8'(bus.mode), 8'd1);
        step(1, 1, 0, 1, 0);
        repeat (5) step(1, 1, 0, 0, 1);
        step(0, 1, 0, 1, 1);
        check("drop_mode", 8'(bus.mode), 8'd0);
        step(0, 0, 0, 0, 0);

        // Random events against the model.
        repeat (4000) begin
            step($urandom_range(0, 299) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 399) == 0,
                 $urandom_range(0, 79) == 0,
                 $urandom_range(0, 7) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
